// File: rtl/sec_to_hms_pkg.sv
// Shared constants and types for the seconds-to-HH:MM:SS converter.
package sec_to_hms_pkg;

    localparam int SEC_PER_HOUR = 3600;
    localparam int SEC_PER_MIN  = 60;
    localparam int HOUR_MOD     = 100;

    // One shared iteration counter serves every division and BCD phase
    localparam int CNT_W       = 6;
    localparam int DIV_M_ITERS = 12;
    localparam int BCD_ITERS   = 7;

    typedef enum logic [2:0] {
        IDLE,
        DIV_H,
        DIV_M,
        MOD_H,
        BCD
    } state_t;

endpackage

// File: rtl/sec_to_hms_if.sv
// Bundle between the timer side and the converter: seconds in, display fields out.
interface sec_to_hms_if #(
    parameter int W = 32
);
    logic [W-1:0] second;
    logic [7:0]   hh;
    logic [7:0]   mm;
    logic [7:0]   ss;
    logic         hr_ovf;
    logic         busy;
    logic         valid;

    modport master (
        output second,
        input  hh, mm, ss, hr_ovf, busy, valid
    );

    modport slave (
        input  second,
        output hh, mm, ss, hr_ovf, busy, valid
    );
endinterface

// File: rtl/sec_to_hms_bin2bcd7.sv
// Double-dabble step register: loads a 7-bit binary value and converts it to
// two packed BCD digits over seven shift steps.
module bin2bcd7
    import sec_to_hms_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       shift,
    input  logic [6:0] din,
    output logic [7:0] bcd_next
);

    // Layout: [14:11] tens digit, [10:7] units digit, [6:0] binary still to shift in
    logic [14:0] sr;
    logic [14:0] sr_next;
    logic [3:0]  lo_adj;
    logic [3:0]  hi_adj;

    // Add-3 correction on each digit followed by a one-bit left shift
    always_comb begin
        lo_adj   = (sr[10:7]  >= 4'd5) ? sr[10:7]  + 4'd3 : sr[10:7];
        hi_adj   = (sr[14:11] >= 4'd5) ? sr[14:11] + 4'd3 : sr[14:11];
        sr_next  = {hi_adj, lo_adj, sr[6:0]} << 1;
        bcd_next = sr_next[14:7];
    end

    // Load clears the digits and seeds the binary operand; shift advances one step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= {8'h00, din};
        end else if (shift) begin
            sr <= sr_next;
        end
    end

endmodule

// File: rtl/sec_to_hms.sv
// Converts the free-running binary seconds count into BCD hours (mod 100),
// minutes and seconds using fixed-latency iterative division, then strobes valid.
module sec_to_hms
    import sec_to_hms_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    sec_to_hms_if.slave  bus
);

    localparam logic [12:0]      HOUR_DIV   = 13'(SEC_PER_HOUR);
    localparam logic [6:0]       MIN_DIV    = 7'(SEC_PER_MIN);
    localparam logic [7:0]       HMOD_DIV   = 8'(HOUR_MOD);
    localparam logic [CNT_W-1:0] LAST_W     = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] LAST_DIV_M = CNT_W'(DIV_M_ITERS - 1);
    localparam logic [CNT_W-1:0] LAST_BCD   = CNT_W'(BCD_ITERS - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     op;
    logic [W-1:0]     last;
    logic [11:0]      rem_h;
    logic [11:0]      quo_m;
    logic [5:0]       rem_m;
    logic [6:0]       rem_c;
    logic             ovf;

    logic [7:0]       hh_q;
    logic [7:0]       mm_q;
    logic [7:0]       ss_q;
    logic             hr_ovf_q;
    logic             busy_q;
    logic             valid_q;

    logic [12:0]      t_h;
    logic             ge_h;
    logic [11:0]      rem_h_next;
    logic [6:0]       t_m;
    logic             ge_m;
    logic [5:0]       rem_m_next;
    logic [11:0]      quo_m_next;
    logic [7:0]       t_c;
    logic             ge_c;
    logic [6:0]       rem_c_next;

    logic             bcd_load;
    logic             bcd_shift;
    logic [7:0]       bcd_h;
    logic [7:0]       bcd_m;
    logic [7:0]       bcd_s;

    // One restoring-division step for each divider; the trial value is one bit
    // wider than the divisor so the compare never overflows
    always_comb begin
        t_h        = {rem_h, op[W-1]};
        ge_h       = (t_h >= HOUR_DIV);
        rem_h_next = ge_h ? 12'(t_h - HOUR_DIV) : t_h[11:0];

        t_m        = {rem_m, quo_m[11]};
        ge_m       = (t_m >= MIN_DIV);
        rem_m_next = ge_m ? 6'(t_m - MIN_DIV) : t_m[5:0];
        quo_m_next = {quo_m[10:0], ge_m};

        t_c        = {rem_c, op[W-1]};
        ge_c       = (t_c >= HMOD_DIV);
        rem_c_next = ge_c ? 7'(t_c - HMOD_DIV) : t_c[6:0];
    end

    assign bcd_load  = (state == MOD_H) && (cnt == LAST_W);
    assign bcd_shift = (state == BCD);

    bin2bcd7 u_bcd_h (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bcd_load),
        .shift    (bcd_shift),
        .din      (rem_c_next),
        .bcd_next (bcd_h)
    );

    bin2bcd7 u_bcd_m (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bcd_load),
        .shift    (bcd_shift),
        .din      (quo_m[6:0]),
        .bcd_next (bcd_m)
    );

    bin2bcd7 u_bcd_s (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (bcd_load),
        .shift    (bcd_shift),
        .din      ({1'b0, rem_m}),
        .bcd_next (bcd_s)
    );

    // Conversion sequencer: detect a new count, divide by 3600, split the
    // remainder by 60, reduce hours mod 100, convert to BCD and publish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op       <= '0;
            last     <= '0;
            rem_h    <= '0;
            quo_m    <= '0;
            rem_m    <= '0;
            rem_c    <= '0;
            ovf      <= 1'b0;
            hh_q     <= 8'h00;
            mm_q     <= 8'h00;
            ss_q     <= 8'h00;
            hr_ovf_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.second != last) begin
                        op     <= bus.second;
                        last   <= bus.second;
                        rem_h  <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= DIV_H;
                    end
                end
                DIV_H: begin
                    op    <= {op[W-2:0], ge_h};
                    rem_h <= rem_h_next;
                    if (cnt == LAST_W) begin
                        quo_m <= rem_h_next;
                        rem_m <= '0;
                        cnt   <= '0;
                        state <= DIV_M;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV_M: begin
                    quo_m <= quo_m_next;
                    rem_m <= rem_m_next;
                    if (cnt == LAST_DIV_M) begin
                        rem_c <= '0;
                        ovf   <= (op >= W'(HOUR_MOD));
                        cnt   <= '0;
                        state <= MOD_H;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MOD_H: begin
                    op    <= {op[W-2:0], ge_c};
                    rem_c <= rem_c_next;
                    if (cnt == LAST_W) begin
                        cnt   <= '0;
                        state <= BCD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BCD: begin
                    if (cnt == LAST_BCD) begin
                        hh_q     <= bcd_h;
                        mm_q     <= bcd_m;
                        ss_q     <= bcd_s;
                        hr_ovf_q <= ovf;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        cnt      <= '0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.hh     = hh_q;
    assign bus.mm     = mm_q;
    assign bus.ss     = ss_q;
    assign bus.hr_ovf = hr_ovf_q;
    assign bus.busy   = busy_q;
    assign bus.valid  = valid_q;

endmodule

// File: tb/tb_sec_to_hms.sv
// Scoreboard bench for sec_to_hms: stimulus pushes hand-computed results with
// their expected strobe cycle, a monitor pops and compares on every valid.
module tb_sec_to_hms;

    typedef struct {
        string      name;
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int   cyc     = 0;
    int   tests   = 0;
    int   fails   = 0;
    int   strobes = 0;
    exp_t exp_q[$];
    exp_t held;
    logic prev_valid = 1'b0;

    sec_to_hms_if #(.W(32)) bus ();

    sec_to_hms #(.W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 10-unit clock period
    always #5 clk = ~clk;

    // Free-running cycle counter for latency checks
    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Drive a new count at a negedge and record the result and strobe cycle expected
    task automatic apply_stimulus(input string name, input logic [31:0] value,
                                  input logic [7:0] eh, input logic [7:0] em,
                                  input logic [7:0] es, input logic eo);
        @(negedge clk);
        bus.second = value;
        exp_q.push_back('{name, eh, em, es, eo, cyc + 84});
    endtask

    // Wait, bounded, until the monitor has consumed every expected result
    task automatic wait_drain(input string name, input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL %s timeout: %0d results pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Monitor: compare every strobe against the scoreboard, and check the
    // outputs hold their last published value between strobes
    always @(negedge clk) begin
        if (!rst_n) begin
            held       = '{"reset", 8'h00, 8'h00, 8'h00, 1'b0, 0};
            prev_valid = 1'b0;
        end else begin
            if (bus.valid === 1'b1) begin
                strobes++;
                check_output("valid_single_cycle", 32'(prev_valid), 32'd0);
                if (exp_q.size() == 0) begin
                    check_output("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_output({e.name, "_hh"},     32'(bus.hh),     32'(e.hh));
                    check_output({e.name, "_mm"},     32'(bus.mm),     32'(e.mm));
                    check_output({e.name, "_ss"},     32'(bus.ss),     32'(e.ss));
                    check_output({e.name, "_hr_ovf"}, 32'(bus.hr_ovf), 32'(e.ovf));
                    check_output({e.name, "_cycle"},  32'(cyc),        32'(e.cyc));
                    check_output({e.name, "_busy"},   32'(bus.busy),   32'd0);
                    held = e;
                end
            end else begin
                check_output("hold_outputs", 32'({bus.hh, bus.mm, bus.ss, bus.hr_ovf}),
                             32'({held.hh, held.mm, held.ss, held.ovf}));
            end
            prev_valid = bus.valid;
        end
    end

    initial begin
        int base;
        bus.second = 32'd0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_hh",     32'(bus.hh),     32'h00);
        check_output("reset_mm",     32'(bus.mm),     32'h00);
        check_output("reset_ss",     32'(bus.ss),     32'h00);
        check_output("reset_hr_ovf", 32'(bus.hr_ovf), 32'd0);
        check_output("reset_busy",   32'(bus.busy),   32'd0);
        check_output("reset_valid",  32'(bus.valid),  32'd0);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check_output("no_valid_after_reset", 32'(strobes), 32'd0);

        apply_stimulus("s59",     32'd59,         8'h00, 8'h00, 8'h59, 1'b0);
        wait_drain("s59", 300);
        apply_stimulus("s3599",   32'd3599,       8'h00, 8'h59, 8'h59, 1'b0);
        wait_drain("s3599", 300);
        apply_stimulus("s3600",   32'd3600,       8'h01, 8'h00, 8'h00, 1'b0);
        wait_drain("s3600", 300);
        apply_stimulus("s359999", 32'd359999,     8'h99, 8'h59, 8'h59, 1'b0);
        wait_drain("s359999", 300);
        apply_stimulus("s360000", 32'd360000,     8'h00, 8'h00, 8'h00, 1'b1);
        wait_drain("s360000", 300);
        apply_stimulus("smax",    32'hFFFF_FFFF,  8'h46, 8'h28, 8'h15, 1'b1);
        wait_drain("smax", 300);

        // Input moves mid-conversion: first result reflects 100, the second 61
        apply_stimulus("mid_first", 32'd100, 8'h00, 8'h01, 8'h40, 1'b0);
        repeat (10) @(negedge clk);
        check_output("mid_busy", 32'(bus.busy), 32'd1);
        bus.second = 32'd61;
        exp_q.push_back('{"mid_second", 8'h00, 8'h01, 8'h01, 1'b0, exp_q[0].cyc + 84});
        wait_drain("mid_change", 400);

        // Reset mid-conversion aborts; a fresh conversion follows release
        @(negedge clk);
        bus.second = 32'd7265;
        repeat (40) @(negedge clk);
        check_output("abort_busy_before", 32'(bus.busy), 32'd1);
        base  = strobes;
        rst_n = 1'b0;
        bus.second = 32'd3600;
        @(negedge clk);
        check_output("abort_hh",     32'(bus.hh),     32'h00);
        check_output("abort_mm",     32'(bus.mm),     32'h00);
        check_output("abort_ss",     32'(bus.ss),     32'h00);
        check_output("abort_hr_ovf", 32'(bus.hr_ovf), 32'd0);
        check_output("abort_busy",   32'(bus.busy),   32'd0);
        check_output("abort_valid",  32'(bus.valid),  32'd0);
        repeat (100) @(negedge clk);
        check_output("abort_no_valid", 32'(strobes - base), 32'd0);
        rst_n = 1'b1;
        exp_q.push_back('{"after_abort", 8'h01, 8'h00, 8'h00, 1'b0, cyc + 84});
        wait_drain("after_abort", 300);
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
